// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory-port arbiter.
// Default sizing matches the accelerator's 128-bit, 32-bit-address memory ports.
package mem_arb_pkg;

  localparam int N_RD_DEF           = 3;
  localparam int AXI_WIDTH_DEF      = 128;
  localparam int AXI_ADDR_WIDTH_DEF = 32;
  localparam int LSB_DEF            = $clog2(AXI_WIDTH_DEF) - 3;
  localparam int MEM_AW             = AXI_ADDR_WIDTH_DEF - LSB_DEF;
  localparam int MEM_STRB_W         = AXI_WIDTH_DEF / 8;

  typedef struct packed {
    logic                valid;
    logic [N_RD_DEF-1:0] id;
  } tag_t;

  // Pointer width for an n-entry ring; a single-entry ring still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// ptr moves to the slot after the winner only when the grant is taken.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = ptr_width(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] nxt;
  logic          found;
  logic          hit;
  int            idx;

  // Scan the ring starting at ptr; first requester wins.
  always_comb begin
    gnt   = {N{1'b0}};
    found = 1'b0;
    hit   = 1'b0;
    idx   = 0;
    nxt   = ptr_q;
    for (int i = 0; i < N; i++) begin
      idx      = int'(ptr_q) + i;
      idx      = (idx >= N) ? idx - N : idx;
      hit      = req[idx] & ~found;
      gnt[idx] = hit;
      nxt      = hit ? PW'((idx + 1 >= N) ? 0 : idx + 1) : nxt;
      found    = found | hit;
    end
    ptr_d = (advance && found) ? nxt : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= {PW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-client arbiter in front of one shared word-addressed RAM port.
// Reads go round-robin, the write either preempts or joins the ring, read data returns via a tag pipeline.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  N_RD           = N_RD_DEF,
  parameter int  AXI_WIDTH      = AXI_WIDTH_DEF,
  parameter int  AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
  parameter int  LSB            = $clog2(AXI_WIDTH) - 3,
  parameter int  RD_LATENCY     = 1,
  parameter int  WR_PRIORITY    = 1,
  parameter type tag_type       = mem_arb_pkg::tag_t,
  localparam int AW             = AXI_ADDR_WIDTH - LSB,
  localparam int SW             = AXI_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_RD-1:0]      rd_req,
  input  logic [N_RD*AW-1:0]   rd_addr,
  output logic [N_RD-1:0]      rd_gnt,
  output logic [N_RD-1:0]      rd_valid,
  output logic [AXI_WIDTH-1:0] rd_data,
  input  logic                 wr_req,
  input  logic [AW-1:0]        wr_addr,
  input  logic [AXI_WIDTH-1:0] wr_data,
  input  logic [SW-1:0]        wr_strb,
  output logic                 wr_gnt,
  output logic                 mem_ren,
  output logic                 mem_wen,
  output logic [AW-1:0]        mem_addr,
  output logic [AXI_WIDTH-1:0] mem_wdata,
  output logic [SW-1:0]        mem_wstrb,
  input  logic [AXI_WIDTH-1:0] mem_rdata
);

  localparam int M = (WR_PRIORITY != 0) ? N_RD : N_RD + 1;

  logic [M-1:0] ring_req;
  logic [M-1:0] ring_gnt;
  logic         ring_advance;

  // Grants are forced low for the whole of every reset cycle.
  generate
    if (WR_PRIORITY != 0) begin : g_wr_first
      assign ring_req = rd_req & {N_RD{~(rst | wr_req)}};
      assign rd_gnt   = ring_gnt;
      assign wr_gnt   = wr_req & ~rst;
    end else begin : g_wr_ring
      assign ring_req = {wr_req, rd_req} & {M{~rst}};
      assign rd_gnt   = ring_gnt[N_RD-1:0];
      assign wr_gnt   = ring_gnt[N_RD];
    end
  endgenerate

  assign ring_advance = ~rst;

  rr_arbiter #(
    .N (M)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (ring_req),
    .advance (ring_advance),
    .gnt     (ring_gnt)
  );

  logic                 mem_ren_q,   mem_ren_d;
  logic                 mem_wen_q,   mem_wen_d;
  logic [AW-1:0]        mem_addr_q,  mem_addr_d;
  logic [AXI_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]        mem_wstrb_q, mem_wstrb_d;
  logic [N_RD-1:0]      rd_id_q,     rd_id_d;
  logic [AW-1:0]        rd_sel_addr;

  // Issue stage: capture the accepted operation for next-cycle presentation to memory.
  always_comb begin
    mem_ren_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rd_id_d     = {N_RD{1'b0}};
    rd_sel_addr = {AW{1'b0}};
    for (int k = 0; k < N_RD; k++) begin
      rd_sel_addr = rd_sel_addr | (rd_addr[k*AW +: AW] & {AW{rd_gnt[k]}});
    end
    if (wr_gnt) begin
      mem_wen_d   = 1'b1;
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
      mem_wstrb_d = wr_strb;
    end else if (|rd_gnt) begin
      mem_ren_d  = 1'b1;
      mem_addr_d = rd_sel_addr;
      rd_id_d    = rd_gnt;
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  // Issue register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {AXI_WIDTH{1'b0}};
      mem_wstrb_q <= {SW{1'b0}};
      rd_id_q     <= {N_RD{1'b0}};
    end else begin
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rd_id_q     <= rd_id_d;
    end
  end

  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  tag_type tag_q [RD_LATENCY];
  tag_type tag_d [RD_LATENCY];

  // Tag shift: entry 0 follows the issued read, the last entry lines up with mem_rdata.
  always_comb begin
    tag_d[0].valid = mem_ren_q;
    tag_d[0].id    = rd_id_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Tag pipeline register; reset flushes every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i].valid <= 1'b0;
        tag_q[i].id    <= {N_RD{1'b0}};
      end
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign rd_valid = (tag_q[RD_LATENCY-1].valid && !rst) ? tag_q[RD_LATENCY-1].id : {N_RD{1'b0}};
  assign rd_data  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiter configurations share one stimulus stream,
// each checked cycle by cycle against its own reference arbiter, memory and read scoreboard.
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int W  = 128;
  localparam int AW = mem_arb_pkg::MEM_AW;
  localparam int SW = mem_arb_pkg::MEM_STRB_W;

  typedef struct {
    int           due;
    logic [N-1:0] id;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst     = 1'b1;
  logic            tb_init = 1'b1;
  logic [N-1:0]    rd_req  = '0;
  logic [N*AW-1:0] rd_addr = '0;
  logic            wr_req  = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [W-1:0]    wr_data = '0;
  logic [SW-1:0]   wr_strb = '0;
  bit              drain_done = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] init_word(input int a);
    logic [7:0] ab;
    ab = a[7:0];
    return {8{ab, 8'hA5}};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int L  = (g == 0) ? 1 : 4;
    localparam int WP = (g == 0) ? 1 : 0;
    localparam int M  = (WP != 0) ? N : N + 1;

    logic [N-1:0]  rd_gnt, rd_valid;
    logic [W-1:0]  rd_data, mem_wdata, mem_rdata;
    logic          wr_gnt, mem_ren, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_wstrb;

    mem_port_arbiter #(
      .N_RD           (N),
      .AXI_WIDTH      (W),
      .AXI_ADDR_WIDTH (32),
      .RD_LATENCY     (L),
      .WR_PRIORITY    (WP)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_gnt    (rd_gnt),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_strb   (wr_strb),
      .wr_gnt    (wr_gnt),
      .mem_ren   (mem_ren),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata)
    );

    // Behavioural RAM with L-cycle read latency, driven by the DUT memory port.
    logic [W-1:0] ram   [0:63];
    logic [W-1:0] rpipe [L];
    assign mem_rdata = rpipe[L-1];

    always @(posedge clk) begin
      if (tb_init) begin
        for (int a = 0; a < 64; a++) ram[a] <= init_word(a);
      end else if (mem_wen) begin
        for (int b = 0; b < SW; b++)
          if (mem_wstrb[b]) ram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      rpipe[0] <= ram[mem_addr[5:0]];
      for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end

    // Reference model and scoreboard.
    logic [W-1:0] ref_mem [0:63];
    exp_t         exp_q [$];

    initial begin : model
      string         pfx;
      int            ptr, cyc, k;
      bit            q_checked;
      logic          e_ren, e_wen, e_zero, x_wgnt;
      logic [AW-1:0] e_addr;
      logic [W-1:0]  e_wdata, x_data;
      logic [SW-1:0] e_wstrb;
      logic [M-1:0]  req;
      logic [N-1:0]  x_rgnt, x_valid;

      pfx = $sformatf("cfg%0d", g);
      ptr = 0; cyc = 0; q_checked = 1'b0;
      e_ren = 1'b0; e_wen = 1'b0; e_zero = 1'b1;
      e_addr = '0; e_wdata = '0; e_wstrb = '0;
      for (int a = 0; a < 64; a++) ref_mem[a] = init_word(a);

      forever begin
        @(negedge clk);
        check_eq({pfx, " mem_ren"}, W'(mem_ren), W'(e_ren));
        check_eq({pfx, " mem_wen"}, W'(mem_wen), W'(e_wen));
        if (e_ren || e_wen || e_zero) check_eq({pfx, " mem_addr"}, W'(mem_addr), W'(e_addr));
        if (e_wen || e_zero) begin
          check_eq({pfx, " mem_wdata"}, mem_wdata, e_wdata);
          check_eq({pfx, " mem_wstrb"}, W'(mem_wstrb), W'(e_wstrb));
        end

        x_valid = '0;
        x_data  = '0;
        if (!rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
          x_valid = exp_q[0].id;
          x_data  = exp_q[0].data;
          void'(exp_q.pop_front());
        end
        check_eq({pfx, " rd_valid"}, W'(rd_valid), W'(x_valid));
        if (x_valid != '0) check_eq({pfx, " rd_data"}, rd_data, x_data);

        x_rgnt = '0;
        x_wgnt = 1'b0;
        k      = -1;
        if (!rst) begin
          if (WP != 0 && wr_req) begin
            x_wgnt = 1'b1;
          end else begin
            req = '0;
            req[N-1:0] = rd_req;
            if (WP == 0) req[M-1] = wr_req;
            for (int i = 0; i < M; i++)
              if (k < 0 && req[(ptr + i) % M]) k = (ptr + i) % M;
            if (k >= 0) begin
              ptr = (k + 1) % M;
              if (k == N) x_wgnt = 1'b1;
              else x_rgnt[k] = 1'b1;
            end
          end
        end
        check_eq({pfx, " rd_gnt"}, W'(rd_gnt), W'(x_rgnt));
        check_eq({pfx, " wr_gnt"}, W'(wr_gnt), W'(x_wgnt));

        e_ren  = 1'b0;
        e_wen  = 1'b0;
        e_zero = 1'b0;
        if (rst) begin
          ptr = 0;
          exp_q.delete();
          e_zero = 1'b1;
          e_addr = '0; e_wdata = '0; e_wstrb = '0;
        end else if (x_wgnt) begin
          e_wen = 1'b1; e_addr = wr_addr; e_wdata = wr_data; e_wstrb = wr_strb;
          for (int b = 0; b < SW; b++)
            if (wr_strb[b]) ref_mem[wr_addr[5:0]][8*b +: 8] = wr_data[8*b +: 8];
        end else if (x_rgnt != '0) begin
          e_ren  = 1'b1;
          e_addr = rd_addr[k*AW +: AW];
          exp_q.push_back('{due: cyc + 1 + L, id: x_rgnt, data: ref_mem[e_addr[5:0]]});
        end
        cyc++;

        if (drain_done && !q_checked) begin
          q_checked = 1'b1;
          check_eq({pfx, " reads outstanding"}, W'(exp_q.size()), W'(0));
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [N-1:0] rq, input int a0, input int a1, input int a2,
                       input logic wq, input int wa, input logic [W-1:0] wd, input logic [SW-1:0] ws);
    rst     = r;
    rd_req  = rq;
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
    wr_req  = wq;
    wr_addr = AW'(wa);
    wr_data = wd;
    wr_strb = ws;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 0, 0, 0, 1'b0, 0, '0, '0);
  endtask

  initial begin
    @(posedge clk);
    #1 tb_init = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    // single read from client 1
    drive(1'b0, 3'b010, 0, 16, 0, 1'b0, 0, '0, '0);
    idle(6);

    // all three clients held
    repeat (6) drive(1'b0, 3'b111, 1, 2, 3, 1'b0, 0, '0, '0);
    idle(6);

    // write competing with reads
    repeat (2) drive(1'b0, 3'b011, 4, 5, 0, 1'b1, 7, {4{32'h1234_5678}}, {SW{1'b1}});
    repeat (2) drive(1'b0, 3'b011, 4, 5, 0, 1'b0, 0, '0, '0);
    idle(6);

    // read-after-write, full then partial strobe
    drive(1'b0, 3'b000, 0, 0, 0, 1'b1, 5, W'(32'hDEAD), {SW{1'b1}});
    drive(1'b0, 3'b100, 0, 0, 5, 1'b0, 0, '0, '0);
    idle(6);
    drive(1'b0, 3'b000, 0, 0, 0, 1'b1, 5, {16{8'hBE}}, 16'h0001);
    drive(1'b0, 3'b100, 0, 0, 5, 1'b0, 0, '0, '0);
    idle(6);

    // random traffic with occasional reset
    repeat (400) begin
      drive(($urandom_range(0, 59) == 0), N'($urandom_range(0, 7)),
            $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 63),
            {$urandom, $urandom, $urandom, $urandom}, SW'($urandom));
    end
    idle(8);

    // reset while two reads are in flight
    drive(1'b0, 3'b001, 9, 0, 0, 1'b0, 0, '0, '0);
    drive(1'b0, 3'b010, 0, 10, 0, 1'b0, 0, '0, '0);
    repeat (2) drive(1'b1, 3'b000, 0, 0, 0, 1'b0, 0, '0, '0);
    idle(6);
    drive(1'b0, 3'b111, 11, 12, 13, 1'b0, 0, '0, '0);
    idle(12);

    drain_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
